// File: rtl/gray_counter_param.sv
// Parametrised Gray-code counter with up/down, parallel load, wrap/saturate,
// sticky overflow/underflow flags, a terminal-count pulse and a binary mirror.
module gray_counter_param #(
    parameter int unsigned WIDTH    = 3,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             ClrFlag,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] BinOut,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Carry
);

    localparam logic [WIDTH-1:0] CntMax = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CntOne = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic             r_carry;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_ovf_evt;
    logic             w_unf_evt;

    // Binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        w_load_bin = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_load_bin[i] = ^(LoadVal >> i);
        end
    end

    assign w_at_max  = (r_cnt == CntMax);
    assign w_at_zero = (r_cnt == '0);
    assign w_ovf_evt = En && !Load && !Dir && w_at_max;
    assign w_unf_evt = En && !Load && Dir && w_at_zero;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (Load) begin
            w_cnt_nxt = w_load_bin;
        end else if (En) begin
            if (!Dir) begin
                if (!w_at_max) begin
                    w_cnt_nxt = r_cnt + CntOne;
                end else if (!SATURATE) begin
                    w_cnt_nxt = '0;
                end
            end else begin
                if (!w_at_zero) begin
                    w_cnt_nxt = r_cnt - CntOne;
                end else if (!SATURATE) begin
                    w_cnt_nxt = CntMax;
                end
            end
        end
    end

    // A terminal event in the same cycle as ClrFlag keeps its own flag set.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_evt || (r_ovf && !ClrFlag);
            r_unf   <= w_unf_evt || (r_unf && !ClrFlag);
            r_carry <= w_ovf_evt || w_unf_evt;
        end
    end

    assign Output    = r_cnt ^ (r_cnt >> 1);
    assign BinOut    = r_cnt;
    assign Overflow  = r_ovf;
    assign Underflow = r_unf;
    assign Carry     = r_carry;

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed bench for gray_counter_param: a WIDTH=3 wrap instance and a
// WIDTH=4 saturating instance, checked through an expected-value queue.
module tb_gray_counter_param;

    logic       Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       a_rst, a_en, a_dir, a_ld, a_clr;
    logic [2:0] a_lv, a_out, a_bin;
    logic       a_ovf, a_unf, a_carry;

    logic       b_rst, b_en, b_dir, b_ld, b_clr;
    logic [3:0] b_lv, b_out, b_bin;
    logic       b_ovf, b_unf, b_carry;

    gray_counter_param #(.WIDTH(3), .SATURATE(1'b0)) u_wrap (
        .Clk       (Clk),
        .Reset     (a_rst),
        .En        (a_en),
        .Dir       (a_dir),
        .Load      (a_ld),
        .LoadVal   (a_lv),
        .ClrFlag   (a_clr),
        .Output    (a_out),
        .BinOut    (a_bin),
        .Overflow  (a_ovf),
        .Underflow (a_unf),
        .Carry     (a_carry)
    );

    gray_counter_param #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
        .Clk       (Clk),
        .Reset     (b_rst),
        .En        (b_en),
        .Dir       (b_dir),
        .Load      (b_ld),
        .LoadVal   (b_lv),
        .ClrFlag   (b_clr),
        .Output    (b_out),
        .BinOut    (b_bin),
        .Overflow  (b_ovf),
        .Underflow (b_unf),
        .Carry     (b_carry)
    );

    typedef struct {
        string tag;
        int    gray;
        int    bin;
        bit    ovf;
        bit    unf;
        bit    carry;
    } exp_t;

    exp_t q_exp[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string tag, input string field, input int obs, input int expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s.%s observed %0d expected %0d", tag, field, obs, expv);
    endtask

    // Drive one cycle on the selected instance, queue its expectation, then
    // pop and compare once the edge has updated the outputs.
    task automatic step(input bit sel, input bit rst, input bit en, input bit dir,
                        input bit ld, input int lv, input bit clr, input string tag,
                        input int g, input int b, input bit o, input bit u, input bit c);
        exp_t e;
        @(negedge Clk);
        if (!sel) begin
            a_rst = rst; a_en = en; a_dir = dir; a_ld = ld; a_lv = lv[2:0]; a_clr = clr;
        end else begin
            b_rst = rst; b_en = en; b_dir = dir; b_ld = ld; b_lv = lv[3:0]; b_clr = clr;
        end
        q_exp.push_back('{tag, g, b, o, u, c});
        @(posedge Clk);
        #1;
        e = q_exp.pop_front();
        if (!sel) begin
            chk(e.tag, "gray", int'(a_out), e.gray);
            chk(e.tag, "bin", int'(a_bin), e.bin);
            chk(e.tag, "ovf", int'(a_ovf), int'(e.ovf));
            chk(e.tag, "unf", int'(a_unf), int'(e.unf));
            chk(e.tag, "carry", int'(a_carry), int'(e.carry));
        end else begin
            chk(e.tag, "gray", int'(b_out), e.gray);
            chk(e.tag, "bin", int'(b_bin), e.bin);
            chk(e.tag, "ovf", int'(b_ovf), int'(e.ovf));
            chk(e.tag, "unf", int'(b_unf), int'(e.unf));
            chk(e.tag, "carry", int'(b_carry), int'(e.carry));
        end
        a_rst = 0; a_en = 0; a_dir = 0; a_ld = 0; a_lv = '0; a_clr = 0;
        b_rst = 0; b_en = 0; b_dir = 0; b_ld = 0; b_lv = '0; b_clr = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int up_gray[8];
        int up_bin[8];
        up_gray = '{1, 3, 2, 6, 7, 5, 4, 0};
        up_bin  = '{1, 2, 3, 4, 5, 6, 7, 0};

        a_rst = 0; a_en = 0; a_dir = 0; a_ld = 0; a_lv = '0; a_clr = 0;
        b_rst = 0; b_en = 0; b_dir = 0; b_ld = 0; b_lv = '0; b_clr = 0;

        // sel, rst, en, dir, ld, lv, clr, tag, gray, bin, ovf, unf, carry
        step(0, 1, 0, 0, 0, 0, 0, "a_reset", 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, 0, 0, 0, $sformatf("a_up%0d", i), up_gray[i], up_bin[i],
                 (i == 7), 0, (i == 7));
        end
        step(0, 0, 0, 0, 0, 0, 0, "a_hold", 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, "a_clr", 0, 0, 0, 0, 0);

        // Down from reset wraps to the top value.
        step(0, 1, 0, 0, 0, 0, 0, "a_reset2", 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, "a_dn_wrap", 4, 7, 0, 1, 1);
        step(0, 0, 1, 1, 0, 0, 0, "a_dn6", 5, 6, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, "a_clr2", 5, 6, 0, 0, 0);

        // Load beats En.
        step(0, 0, 0, 0, 1, 2, 0, "a_ld010", 2, 3, 0, 0, 0);
        step(0, 0, 1, 0, 1, 7, 0, "a_ld111_en", 7, 5, 0, 0, 0);

        // Set-wins against ClrFlag; the other sticky flag clears.
        step(0, 0, 0, 0, 1, 0, 0, "a_ld000", 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0, "a_unf_set", 4, 7, 0, 1, 1);
        step(0, 0, 1, 0, 0, 0, 0, "a_ovf_set", 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 1, 4, 0, "a_ld100", 4, 7, 1, 1, 0);
        step(0, 0, 1, 0, 0, 0, 1, "a_clr_evt", 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, "a_clr_idle", 0, 0, 0, 0, 0);

        // ClrFlag honoured alongside Load.
        step(0, 0, 1, 1, 0, 0, 0, "a_unf_again", 4, 7, 0, 1, 1);
        step(0, 0, 0, 0, 1, 3, 1, "a_ld_clr", 3, 2, 0, 0, 0);

        // Reset mid-count overrides Load and En.
        step(0, 1, 0, 0, 0, 0, 0, "a_reset3", 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 0, 0, 0, $sformatf("a_re%0d", i), up_gray[i], up_bin[i], 0, 0, 0);
        end
        step(0, 1, 1, 0, 1, 7, 0, "a_reset_mid", 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, "a_resume", 1, 1, 0, 0, 0);

        // Saturating WIDTH=4 instance.
        step(1, 1, 0, 0, 0, 0, 0, "b_reset", 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 8, 0, "b_ld1000", 8, 15, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0, 0, 0, 0, $sformatf("b_sat_up%0d", i), 8, 15, 1, 0, 1);
        end
        step(1, 0, 1, 1, 0, 0, 0, "b_dn14", 9, 14, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 1, "b_ld0_clr", 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 1, 1, 0, 0, 0, $sformatf("b_sat_dn%0d", i), 0, 0, 0, 1, 1);
        end
        step(1, 0, 0, 0, 0, 0, 0, "b_idle", 0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
Parametrised, enable-gated Gray-code counter. It supersedes the fixed 3-bit Gray counter, adding:
- configurable width;
- up/down direction;
- parallel load of a Gray value;
- wrap or saturate mode;
- separate sticky overflow and underflow flags with explicit clear;
- a one-cycle wrap pulse;
- a binary-coded mirror output.

It is used as a standalone sequencer/pointer source in single-clock datapaths.

Parameters:
WIDTH, 3, counter width in bits (>=2).
SATURATE, 0, 0 = wrap at terminal count; 1 = hold at terminal count.

Ports:
Clk  input  1  system clock, all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
En  input  1  count enable; one step per cycle while high.
Dir  input  1  0 = count up, 1 = count down.
Load  input  1  parallel load strobe.
LoadVal  input  WIDTH  Gray-coded value to load.
ClrFlag  input  1  clears Overflow and Underflow.
Output  output  WIDTH  current count, Gray code.
BinOut  output  WIDTH  current count, binary.
Overflow  output  1  sticky, set on up-count past maximum.
Underflow  output  1  sticky, set on down-count past zero.
Carry  output  1  single-cycle pulse marking a terminal-count event.

Behaviour:
- State:
  - One binary register cnt[WIDTH-1:0].
  - Output = cnt ^ (cnt >> 1); BinOut = cnt. Both are driven from the register only, with no combinational path from any input.
  - Registered flags: Overflow, Underflow, Carry.
- Reset (sync, active-high; highest priority, may assert mid-count):
  - Next edge: cnt=0, Output=0, BinOut=0, Overflow=0, Underflow=0, Carry=0.
  - All other inputs are ignored that cycle.
- Priority below Reset: Load > En. ClrFlag is evaluated independently.
- Load=1:
  - cnt <= Gray-to-binary(LoadVal), where b[W-1]=g[W-1] and b[i]=b[i+1]^g[i].
  - No count occurs that cycle, even if En=1.
  - Flags are unchanged except by ClrFlag. Carry=0 next cycle.
- En=1, Load=0, Dir=0:
  - If cnt != 2^WIDTH-1: cnt <= cnt+1.
  - At cnt == 2^WIDTH-1 (terminal event):
    - SATURATE=0: cnt <= 0.
    - SATURATE=1: cnt holds.
    - In both modes Overflow <= 1 and Carry <= 1.
- En=1, Load=0, Dir=1:
  - If cnt != 0: cnt <= cnt-1.
  - At cnt == 0 (terminal event):
    - SATURATE=0: cnt <= 2^WIDTH-1.
    - SATURATE=1: cnt holds.
    - In both modes Underflow <= 1 and Carry <= 1.
- En=0, Load=0: cnt holds.
- Carry:
  - High for exactly the one cycle following a terminal event, concurrent with the post-event Output.
  - Consecutive terminal events (saturate mode with En held) keep Carry high on each following cycle.
- Flags:
  - Overflow and Underflow remain 1 until Reset or ClrFlag.
  - ClrFlag=1 clears both on the next edge.
  - If a terminal event occurs in the same cycle as ClrFlag, set wins for the flag that event sets; the other flag clears.
  - ClrFlag is honoured alongside Load.
- Latency: one cycle from input edge to Output/BinOut/flag change.
- Gray property: in wrap mode, successive counted values of Output differ in exactly one bit, including across the wrap. A load may change several bits.

Test Plan:
- WIDTH=3, SATURATE=0; Reset 1 cycle, then En=1, Dir=0 for 8 cycles -> Output 000,001,011,010,110,111,101,100,000. Overflow=1 from the 8th step onward, Carry=1 only on that cycle, Underflow=0.
- WIDTH=3, SATURATE=0; from reset, En=1, Dir=1 for 1 cycle -> Output=100, BinOut=7, Underflow=1, Carry=1. Next down step -> Output=101, BinOut=6, Carry=0, Underflow still 1.
- WIDTH=4, SATURATE=1; Load=1, LoadVal=1000 -> BinOut=15. Then En=1, Dir=0 for 3 cycles -> Output stays 1000, Overflow=1, Carry=1 for all 3 cycles.
- WIDTH=3; at Output=010, assert Load=1 (LoadVal=111) together with En=1 -> Output=111 (BinOut=5) next cycle, no increment, Carry=0.
- WIDTH=3, SATURATE=0; Overflow already 1 with cnt=7; ClrFlag=1 and En=1, Dir=0 same cycle -> Output=000, Overflow=1 (set wins). Then ClrFlag=1 with En=0 -> Overflow=0.
- Mid-count at Output=110, assert Reset with En=1, Load=1 -> next edge all outputs 0. Counting resumes 000->001 on the first enabled cycle after Reset drops.
